// File: rtl/iter_shift_unit.sv
// Multi-cycle SLL/SRL/SRA/ROTR unit: moves at most STEP bit positions per cycle
// and reports completion with a one-cycle done pulse.

module iter_shift_step #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic [1:0]       op_i,
  input  logic [SHW:0]     s_i,
  output logic [WIDTH-1:0] y_o
);
  logic [2*WIDTH-1:0] dbl;

  always_comb begin
    // Rotating right is the low half of the doubled word shifted right.
    dbl = {val_i, val_i} >> s_i;
    case (op_i)
      2'b00:   y_o = val_i << s_i;
      2'b01:   y_o = val_i >> s_i;
      2'b10:   y_o = $unsigned($signed(val_i) >>> s_i);
      default: y_o = dbl[WIDTH-1:0];
    endcase
  end
endmodule

module iter_shift_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             use_reg,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] operand,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] amt_out
);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  // One bit wider than SHW so STEP == WIDTH is representable.
  localparam logic [SHW:0] STEP_L = (SHW+1)'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d, result_q, result_d, shifted;
  logic [1:0]       op_q, op_d;
  logic [SHW-1:0]   rem_q, rem_d, amt_q, amt_d, amt_sel, rem_step;
  logic [SHW:0]     step_amt;
  logic             accept;
  logic             rs_unused;

  assign rs_unused = ^rs_val[WIDTH-1:SHW];
  assign amt_sel   = use_reg ? rs_val[SHW-1:0] : shamt;
  assign accept    = start && (state_q != S_SHIFT);
  assign step_amt  = ({1'b0, rem_q} < STEP_L) ? {1'b0, rem_q} : STEP_L;
  assign rem_step  = rem_q - step_amt[SHW-1:0];

  iter_shift_step #(.WIDTH(WIDTH), .SHW(SHW)) u_step (
    .val_i (work_q),
    .op_i  (op_q),
    .s_i   (step_amt),
    .y_o   (shifted)
  );

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    op_d     = op_q;
    rem_d    = rem_q;
    amt_d    = amt_q;
    result_d = result_q;
    case (state_q)
      S_SHIFT: begin
        work_d = shifted;
        rem_d  = rem_step;
        if (rem_step == '0) begin
          result_d = shifted;
          state_d  = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          work_d = operand;
          op_d   = op;
          rem_d  = amt_sel;
          amt_d  = amt_sel;
          if (amt_sel == '0) begin
            result_d = operand;
            state_d  = S_DONE;
          end else begin
            state_d  = S_SHIFT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      work_q   <= '0;
      op_q     <= '0;
      rem_q    <= '0;
      amt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
      amt_q    <= amt_d;
      result_q <= result_d;
    end
  end

  assign busy    = (state_q == S_SHIFT);
  assign done    = (state_q == S_DONE);
  assign result  = result_q;
  assign amt_out = {{(WIDTH-SHW){1'b0}}, amt_q};
endmodule

// File: tb/tb_iter_shift_unit.sv
// Scoreboard bench for iter_shift_unit: expectations are queued at issue and
// compared when the done pulse arrives.

module tb_iter_shift_unit;
  localparam int W = 32, SHW = 5, STEP = 4;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, use_reg = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [SHW-1:0] shamt = '0;
  logic [W-1:0]  rs_val = '0, operand = '0;
  logic          busy, done;
  logic [W-1:0]  result, amt_out;

  int pass_cnt = 0, total = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] amt;
    int           edges;
  } exp_t;
  exp_t sb[$];

  iter_shift_unit #(.WIDTH(W), .SHW(SHW), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .use_reg(use_reg),
    .shamt(shamt), .rs_val(rs_val), .operand(operand),
    .busy(busy), .done(done), .result(result), .amt_out(amt_out)
  );

  always #5 clk = ~clk;

  // Reference: one-shot shift by the full amount.
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] v, input int a);
    case (o)
      2'b00:   return v << a;
      2'b01:   return v >> a;
      2'b10:   return $unsigned($signed(v) >>> a);
      default: return (a == 0) ? v : ((v >> a) | (v << (W - a)));
    endcase
  endfunction

  function automatic int exp_edges(input int a);
    return (a == 0) ? 1 : (a + STEP - 1) / STEP + 1;
  endfunction

  task automatic drive(input logic [1:0] o, input logic ur, input logic [SHW-1:0] sh,
                       input logic [W-1:0] rs, input logic [W-1:0] opd);
    op = o; use_reg = ur; shamt = sh; rs_val = rs; operand = opd; start = 1'b1;
  endtask

  // Issues the already-driven request and follows it to its done pulse.
  task automatic wait_done(output logic [W-1:0] res, output logic [W-1:0] amt,
                           output int edges, output int bc, output bit ok);
    @(posedge clk); #1;
    start = 1'b0; edges = 1; bc = 0; ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (done) begin ok = 1'b1; break; end
      if (busy) bc++;
      @(posedge clk); #1;
      edges++;
    end
    res = result; amt = amt_out;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset busy got %b want 0", busy); else pass_cnt++;
    total++; if (done !== 1'b0) $display("FAIL reset done got %b want 0", done); else pass_cnt++;
    total++; if (result !== '0) $display("FAIL reset result got %h want 0", result); else pass_cnt++;
    total++; if (amt_out !== '0) $display("FAIL reset amt_out got %h want 0", amt_out); else pass_cnt++;
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_table();
    logic [1:0]     t_op [7] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd1, 2'd2, 2'd3};
    logic           t_ur [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [SHW-1:0] t_sh [7] = '{5'd31, 5'd0, 5'd0, 5'd8, 5'd0, 5'd31, 5'd0};
    logic [W-1:0]   t_rs [7] = '{32'h0, 32'hFFFFFFE4, 32'hFFFFFFE4, 32'h0, 32'h0, 32'h0, 32'hABCDE01F};
    logic [W-1:0]   t_v  [7] = '{32'h1, 32'h80000000, 32'h80000000, 32'h12345678,
                                 32'h80000000, 32'h80000000, 32'h00000001};
    logic [W-1:0]   t_res[7] = '{32'h80000000, 32'hF8000000, 32'h08000000, 32'h78123456,
                                 32'h80000000, 32'hFFFFFFFF, 32'h00000002};
    logic [W-1:0]   t_amt[7] = '{32'h1F, 32'h4, 32'h4, 32'h8, 32'h0, 32'h1F, 32'h1F};
    int             t_ed [7] = '{9, 2, 2, 3, 1, 9, 9};
    logic [W-1:0] r, a; int ed, bc; bit ok; exp_t e;
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{res: t_res[i], amt: t_amt[i], edges: t_ed[i]});
      drive(t_op[i], t_ur[i], t_sh[i], t_rs[i], t_v[i]);
      wait_done(r, a, ed, bc, ok);
      e = sb.pop_front();
      total++; if (!ok) $display("FAIL tbl[%0d] timeout no done", i); else pass_cnt++;
      total++; if (r !== e.res) $display("FAIL tbl[%0d] result got %h want %h", i, r, e.res); else pass_cnt++;
      total++; if (a !== e.amt) $display("FAIL tbl[%0d] amt_out got %h want %h", i, a, e.amt); else pass_cnt++;
      total++; if (ed !== e.edges) $display("FAIL tbl[%0d] latency got %0d want %0d", i, ed, e.edges); else pass_cnt++;
      total++; if (bc !== e.edges - 1) $display("FAIL tbl[%0d] busy cycles got %0d want %0d", i, bc, e.edges - 1); else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignore_start();
    int ed; bit ok; exp_t e;
    sb.push_back('{res: 32'h00100000, amt: 32'h14, edges: 6});
    drive(2'd0, 1'b0, 5'd20, 32'h0, 32'h1);
    @(posedge clk); #1;
    ed = 1; ok = 1'b0;
    // Conflicting requests presented for the edges 2..4 while shifting.
    drive(2'd3, 1'b1, 5'd3, 32'h7, 32'hFFFF0000);
    for (int i = 0; i < 64; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      ed++;
      if (ed >= 4) start = 1'b0;
    end
    start = 1'b0;
    e = sb.pop_front();
    total++; if (!ok) $display("FAIL ignore timeout no done"); else pass_cnt++;
    total++; if (result !== e.res) $display("FAIL ignore result got %h want %h", result, e.res); else pass_cnt++;
    total++; if (amt_out !== e.amt) $display("FAIL ignore amt_out got %h want %h", amt_out, e.amt); else pass_cnt++;
    total++; if (ed !== e.edges) $display("FAIL ignore latency got %0d want %0d", ed, e.edges); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int dones = 0;
    drive(2'd0, 1'b0, 5'd31, 32'h0, 32'h1);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b1) $display("FAIL abort pre busy got %b want 1", busy); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL abort busy got %b want 0", busy); else pass_cnt++;
    total++; if (done !== 1'b0) $display("FAIL abort done got %b want 0", done); else pass_cnt++;
    total++; if (result !== '0) $display("FAIL abort result got %h want 0", result); else pass_cnt++;
    total++; if (amt_out !== '0) $display("FAIL abort amt_out got %h want 0", amt_out); else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    total++; if (dones !== 0) $display("FAIL abort activity got %0d cycles want 0", dones); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r, a; int ed, bc; bit ok; exp_t e;
    sb.push_back('{res: 32'h00000300, amt: 32'h8, edges: 3});
    drive(2'd0, 1'b0, 5'd8, 32'h0, 32'h3);
    wait_done(r, a, ed, bc, ok);
    e = sb.pop_front();
    total++; if (!ok || r !== e.res) $display("FAIL b2b first result got %h want %h", r, e.res); else pass_cnt++;
    // Still in the DONE cycle: the next request must be taken at the coming edge.
    sb.push_back('{res: 32'h000000F0, amt: 32'h4, edges: 2});
    drive(2'd0, 1'b0, 5'd4, 32'h0, 32'hF);
    wait_done(r, a, ed, bc, ok);
    e = sb.pop_front();
    total++; if (!ok) $display("FAIL b2b timeout no done"); else pass_cnt++;
    total++; if (r !== e.res) $display("FAIL b2b result got %h want %h", r, e.res); else pass_cnt++;
    total++; if (ed !== e.edges) $display("FAIL b2b latency got %0d want %0d", ed, e.edges); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [W-1:0] r, a, rs, v; logic [1:0] o; logic ur; logic [SHW-1:0] sh;
    int amt, ed, bc; bit ok; exp_t e;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3)); ur = 1'($urandom_range(0, 1));
      sh = SHW'($urandom_range(0, 31)); rs = $urandom(); v = $urandom();
      amt = ur ? int'(rs[SHW-1:0]) : int'(sh);
      sb.push_back('{res: model(o, v, amt), amt: W'(amt), edges: exp_edges(amt)});
      drive(o, ur, sh, rs, v);
      wait_done(r, a, ed, bc, ok);
      e = sb.pop_front();
      total++;
      if (!ok || r !== e.res || a !== e.amt || ed !== e.edges)
        $display("FAIL rnd[%0d] op=%0d v=%h amt=%0d got %h/%h/%0d want %h/%h/%0d",
                 i, o, v, amt, r, a, ed, e.res, e.amt, e.edges);
      else pass_cnt++;
      if (i % 3 == 0) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    test_reset();
    test_table();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/iter_shift_unit.md
Name: iter_shift_unit

Overview:
- Multi-cycle shift execution unit for the MIPS datapath, with a start/busy/done handshake.
- Supports SLL/SRL/SRA/ROTR.
- Shift amount comes either from the instruction shamt field or from the low bits of rs (variable shifts).
- Also exports the latched shift amount zero-extended to the full datapath width for ALU/forwarding use.
- Successor to the fixed 5-to-32 zero-extender: width, amount width and per-cycle shift step are parametrised.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHW, 5, shift-amount width; must equal log2(WIDTH).
- STEP, 4, maximum bit positions shifted per cycle; power of 2, 1 to WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a shift; sampled only when not busy.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTR (rotate right).
- use_reg  input  1  1: amount = rs_val[SHW-1:0]; 0: amount = shamt.
- shamt  input  SHW  immediate shift amount.
- rs_val  input  WIDTH  register operand supplying the variable amount.
- operand  input  WIDTH  value to shift (rt).
- busy  output  1  high while in SHIFT state.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  shifted value; held until the next accepted start or reset.
- amt_out  output  WIDTH  {WIDTH-SHW zeros, latched amount}.

Behaviour:
- Reset: synchronous; rst high at an edge forces state IDLE, busy=0, done=0, result=0, amt_out=0. Reset overrides start and aborts any in-flight shift; no done is produced for an aborted operation.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1.
  - DONE: done=1, busy=0.
- Accept: at an edge with state IDLE or DONE and start=1, the unit latches operand into the working register, latches op, and latches amt = use_reg ? rs_val[SHW-1:0] : shamt. amt_out updates at the same edge.
- Next state after accept: SHIFT if amt != 0. If amt == 0, go to DONE, and result = operand at that edge.
- start while in SHIFT is ignored; the latched values are unaffected.
- SHIFT step: at each edge, s = min(remaining, STEP).
  - Working register shifted by s: SLL fills 0; SRL fills 0; SRA fills the sign bit of the current working value; ROTR rotates.
  - remaining -= s.
  - If the new remaining is 0: the shifted value is written to result and the next state is DONE.
- Latency: done is high in the cycle following edge number ceil(amt/STEP)+1 counted from the accept edge (the accept edge is edge 1). For amt=0, done is high after 1 edge.
- DONE lasts exactly one cycle.
  - start=1 in DONE: accepted (back-to-back issue, no bubble).
  - Otherwise: next state IDLE.
- result and amt_out hold their values through IDLE.
- Max amount is 2^SHW-1; a shift by WIDTH cannot be expressed. Only the low SHW bits of rs_val are used; upper bits are ignored.
- Final results must be bit-exact with a single-cycle shift by amt for all four ops.

Test Plan:
- SLL, use_reg=0, shamt=31, operand=0x00000001 (STEP=4) -> result=0x80000000; done after 9 edges; busy high 8 cycles; amt_out=0x0000001F.
- SRA, use_reg=1, rs_val=0xFFFFFFE4, operand=0x80000000 -> amt_out=0x00000004; result=0xF8000000; done after 2 edges. Same stimulus with SRL -> 0x08000000.
- ROTR by 8, operand=0x12345678 -> 0x78123456. SRL with shamt=0, operand=0x80000000 -> done after 1 edge, result=0x80000000, busy never high.
- Issue SLL by 20 on 0x1; pulse start with other operands on cycles 2-4 -> those requests are ignored; result=0x00100000.
- Assert rst during the 3rd SHIFT cycle -> next cycle busy=0, done=0, result=0, amt_out=0; no done pulse follows.
- Hold start=1 in the DONE cycle with new operands (SLL 4 on 0xF) -> accepted immediately; the following done yields 0x000000F0.
